mem_chan_req: RTL and testbench

- Parametrised N-channel toggle-request generator between the console core's memory ports (ROM, WRAM, BSRAM, VRAM halves, ARAM) and the SDRAM controller's toggle req/ack channels.
- Per channel it detects rd/wr rising edges and address changes, issues toggle requests, and defers requests while the controller is busy.
- While reset is held, it runs a handshaked zero-fill sweep on selected channels.
- Supersedes the per-channel ad-hoc request logic in top levels.

---
 rtl/mem_chan_req.sv | 167 ++++++++++++++++
 tb/tb_mem_chan_req.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_chan_req.sv
// N-channel toggle req/ack generator between core memory ports and the SDRAM controller.
// Optional sticky overrun flags are built only when MEM_REQ_OVR_EN is defined.
module mem_chan_req #(
    parameter int unsigned       NCH         = 5,
    parameter int unsigned       AW          = 24,
    parameter logic [NCH-1:0]    CLR_MASK    = 5'b01100,
    parameter int unsigned       CLR_AW      = 15,
    parameter logic [NCH-1:0]    RETRIG_MASK = 5'b11111
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [NCH*AW-1:0]   ch_addr,
    input  logic [NCH-1:0]      ch_rd,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [NCH*8-1:0]    ch_din,
    input  logic [NCH-1:0]      mem_ack,
    output logic [NCH-1:0]      mem_req,
    output logic [NCH*AW-1:0]   mem_addr,
    output logic [NCH*8-1:0]    mem_din,
    output logic [NCH-1:0]      mem_we,
    output logic [NCH-1:0]      ch_busy,
    output logic [NCH-1:0]      ch_ovr,
    output logic                clr_done
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DONE
    } clr_state_t;

    clr_state_t          r_state;
    clr_state_t          w_state_nxt;
    logic [CLR_AW-1:0]   r_clr_addr;
    logic                r_clr_done;
    logic                w_clr_step;
    logic                w_clr_quiet;
    logic                w_clr_last;
    logic [NCH-1:0]      w_req_eq_ack;

    // Sweep only advances when every clear channel has its previous request acked.
    assign w_clr_quiet = ((~w_req_eq_ack) & CLR_MASK) == '0;
    assign w_clr_last  = (r_clr_addr == {CLR_AW{1'b1}});
    assign clr_done    = r_clr_done;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request still in flight when the sweep starts is waited out before stepping.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_step  = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_STEP;
            S_STEP: begin
                if (w_clr_quiet) begin
                    w_clr_step  = reset;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_clr_quiet) begin
                    w_state_nxt = w_clr_last ? S_DONE : S_STEP;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    r_clr_addr <= '0;
                    r_clr_done <= 1'b0;
                end
                S_WAIT: begin
                    if (w_clr_quiet && !w_clr_last) begin
                        r_clr_addr <= r_clr_addr + CLR_AW'(1);
                    end
                end
                S_DONE:  r_clr_done <= 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic          r_rd_d;
        logic          r_wr_d;
        logic          r_req;
        logic          r_pending;
        logic          r_hold_we;
        logic [AW-1:0] r_addr_last;
        logic [AW-1:0] r_hold_addr;
        logic [AW-1:0] w_addr;
        logic          w_trig;
        logic          w_issue;
        logic          w_clr_ch;
        logic          w_tog;

        assign w_addr   = ch_addr[i*AW +: AW];
        assign w_trig   = (ch_rd[i] & ~r_rd_d) | (ch_wr[i] & ~r_wr_d)
                        | (RETRIG_MASK[i] & (ch_rd[i] | ch_wr[i]) & (w_addr != r_addr_last));
        assign w_issue  = ~reset & (w_trig | r_pending) & (r_req == mem_ack[i]);
        assign w_clr_ch = reset & CLR_MASK[i];
        assign w_tog    = w_issue | (w_clr_step & CLR_MASK[i]);

        assign w_req_eq_ack[i]        = (r_req == mem_ack[i]);
        assign mem_req[i]             = r_req ^ w_tog;
        assign mem_addr[i*AW +: AW]   = w_clr_ch ? AW'(r_clr_addr) : (w_issue ? w_addr : r_hold_addr);
        assign mem_we[i]              = w_clr_ch ? 1'b1 : (w_issue ? ch_wr[i] : r_hold_we);
        assign mem_din[i*DW +: DW]    = w_clr_ch ? '0 : ch_din[i*DW +: DW];
        assign ch_busy[i]             = (mem_req[i] != mem_ack[i]) | r_pending;

        // Request phase is never reset so it stays aligned with the controller's ack.
        always_ff @(posedge clk_sys) begin
            r_req <= r_req ^ w_tog;
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_rd_d      <= 1'b0;
                r_wr_d      <= 1'b0;
                r_pending   <= 1'b0;
                r_addr_last <= '1;
                r_hold_addr <= '0;
                r_hold_we   <= 1'b0;
            end else begin
                r_rd_d      <= ch_rd[i];
                r_wr_d      <= ch_wr[i];
                r_addr_last <= w_addr;
                if (w_issue) begin
                    r_pending   <= 1'b0;
                    r_hold_addr <= w_addr;
                    r_hold_we   <= ch_wr[i];
                end else if (w_trig) begin
                    r_pending   <= 1'b1;
                end
            end
        end

`ifdef MEM_REQ_OVR_EN
        logic r_ovr;
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_ovr <= 1'b0;
            end else if (w_trig && r_pending) begin
                r_ovr <= 1'b1;
            end
        end
        assign ch_ovr[i] = r_ovr;
`else
        assign ch_ovr[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_chan_req.sv
// Directed bench for mem_chan_req: echo-ack controller model, toggle recorder, hand-computed checks.
module tb_mem_chan_req;
    localparam int unsigned NCH = 5;
    localparam int unsigned AW  = 24;
`ifdef MEM_REQ_OVR_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic                reset;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH-1:0]      ch_rd, ch_wr;
    logic [NCH*8-1:0]    ch_din;
    logic [NCH-1:0]      mem_ack, mem_req, mem_we, ch_busy, ch_ovr;
    logic [NCH*AW-1:0]   mem_addr;
    logic [NCH*8-1:0]    mem_din;
    logic                clr_done;

    logic [NCH-1:0]      ack2, req2, we2, busy2, ovr2;
    logic [NCH*AW-1:0]   addr2;
    logic [NCH*8-1:0]    din2;
    logic                done2;

    mem_chan_req #(.NCH(NCH), .AW(AW), .CLR_MASK(5'b01100), .CLR_AW(4), .RETRIG_MASK(5'b11111)) dut (
        .clk_sys(clk_sys), .reset(reset), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_din(ch_din), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_we(mem_we), .ch_busy(ch_busy), .ch_ovr(ch_ovr), .clr_done(clr_done));

    mem_chan_req #(.NCH(NCH), .AW(AW), .CLR_MASK(5'b01100), .CLR_AW(4), .RETRIG_MASK(5'b11110)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_din(ch_din), .mem_ack(ack2), .mem_req(req2), .mem_addr(addr2),
        .mem_din(din2), .mem_we(we2), .ch_busy(busy2), .ch_ovr(ovr2), .clr_done(done2));

    // Controller model: ack echoes req after (ack_dly+1) cycles.
    logic [3:0]     ack_dly = 4'd1;
    logic [NCH-1:0] pipe  [16] = '{default: '0};
    logic [NCH-1:0] pipe2 [16] = '{default: '0};
    always @(posedge clk_sys) begin
        pipe[0]  <= mem_req;
        pipe2[0] <= req2;
        for (int k = 1; k < 16; k++) begin
            pipe[k]  <= pipe[k-1];
            pipe2[k] <= pipe2[k-1];
        end
    end
    assign mem_ack = pipe[ack_dly];
    assign ack2    = pipe2[ack_dly];

    // Toggle recorder.
    int             tog [NCH] = '{default: 0};
    int             tog2      = 0;
    logic [AW-1:0]  last_addr [NCH];
    logic           last_we   [NCH];
    logic [AW-1:0]  log_addr  [2][32];
    int             log_bad   [2] = '{default: 0};
    logic [NCH-1:0] prev_req  = '0;
    logic           prev2     = 1'b0;
    always @(posedge clk_sys) begin
        for (int i = 0; i < NCH; i++) begin
            if (mem_req[i] != prev_req[i]) begin
                tog[i]       <= tog[i] + 1;
                last_addr[i] <= mem_addr[i*AW +: AW];
                last_we[i]   <= mem_we[i];
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (mem_req[c+2] != prev_req[c+2] && tog[c+2] < 32) begin
                log_addr[c][tog[c+2]] <= mem_addr[(c+2)*AW +: AW];
                if (!mem_we[c+2] || mem_din[(c+2)*8 +: 8] != 8'h00) log_bad[c] <= log_bad[c] + 1;
            end
        end
        prev_req <= mem_req;
        if (req2[0] != prev2) tog2 <= tog2 + 1;
        prev2 <= req2[0];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        ch_addr[ch*AW +: AW] = a;
    endtask

    int  b, b2, nb;
    logic found;

    initial begin
        reset   = 1'b1;
        ch_addr = '0;
        ch_rd   = '0;
        ch_wr   = '0;
        ch_din  = '0;

        // Reset sweep: CLR_AW=4, ack after 2 cycles.
        tick(2);
        check("rst_busy0", 32'(ch_busy[0]), 0);
        check("rst_ovr", 32'(ch_ovr), 0);
        check("rst_clr_done", 32'(clr_done), 0);
        tick(198);
        check("clr_done", 32'(clr_done), 1);
        check("clr_tog2", 32'(tog[2]), 16);
        check("clr_tog3", 32'(tog[3]), 16);
        check("clr_tog0", 32'(tog[0]), 0);
        check("clr_tog1", 32'(tog[1]), 0);
        check("clr_tog4", 32'(tog[4]), 0);
        for (int k = 0; k < 16; k++) begin
            check("clr_addr2", 32'(log_addr[0][k]), 32'(k));
            check("clr_addr3", 32'(log_addr[1][k]), 32'(k));
        end
        check("clr_we_din2", 32'(log_bad[0]), 0);
        check("clr_we_din3", 32'(log_bad[1]), 0);
        reset = 1'b0;
        tick(20);
        check("clr_done_hold", 32'(clr_done), 1);

        // Single read, ack after 4 cycles.
        ack_dly = 4'd3;
        b = tog[0];
        set_addr(0, 24'h000100);
        ch_rd[0] = 1'b1;
        #1;
        check("rd_same_cycle", 32'(mem_req[0] ^ mem_ack[0]), 1);
        check("rd_addr", 32'(mem_addr[0 +: AW]), 32'h100);
        check("rd_we", 32'(mem_we[0]), 0);
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            if (ch_busy[0]) nb++;
            tick();
        end
        check("rd_busy_cycles", 32'(nb), 4);
        check("rd_one_toggle", 32'(tog[0] - b), 1);
        ch_rd[0] = 1'b0;
        tick(3);

        // Address retrigger with rd held, idle controller.
        b  = tog[0];
        b2 = tog2;
        set_addr(0, 24'h10);
        ch_rd[0] = 1'b1;
        tick(6);
        set_addr(0, 24'h11);
        tick(6);
        set_addr(0, 24'h12);
        tick(6);
        ch_rd[0] = 1'b0;
        tick(6);
        check("retrig_toggles", 32'(tog[0] - b), 3);
        check("retrig_last_addr", 32'(last_addr[0]), 32'h12);
        check("noretrig_toggles", 32'(tog2 - b2), 1);

        // Write deferred behind an unacked read.
        b = tog[0];
        set_addr(0, 24'h30);
        ch_rd[0] = 1'b1;
        tick();
        ch_rd[0] = 1'b0;
        ch_wr[0] = 1'b1;
        set_addr(0, 24'h20);
        ch_din[7:0] = 8'hA5;
        #1;
        check("defer_no_issue_addr", 32'(mem_addr[0 +: AW]), 32'h30);
        check("defer_busy", 32'(ch_busy[0]), 1);
        check("defer_din", 32'(mem_din[7:0]), 32'hA5);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (tog[0] - b == 2) found = 1'b1;
        end
        check("defer_issued", 32'(found), 1);
        check("defer_addr", 32'(last_addr[0]), 32'h20);
        check("defer_we", 32'(last_we[0]), 1);
        tick(10);
        check("defer_single", 32'(tog[0] - b), 2);
        ch_wr[0] = 1'b0;
        tick(10);

        // Three triggers in one busy window coalesce.
        ack_dly = 4'd7;
        b = tog[0];
        set_addr(0, 24'h40);
        ch_rd[0] = 1'b1;
        tick();
        set_addr(0, 24'h41);
        tick();
        set_addr(0, 24'h42);
        tick();
        set_addr(0, 24'h43);
        tick(20);
        check("coal_toggles", 32'(tog[0] - b), 2);
        check("coal_addr", 32'(last_addr[0]), 32'h43);
        check("coal_ovr", 32'(ch_ovr[0]), 32'(OVR_EXP));
        check("coal_idle", 32'(ch_busy[0]), 0);
        ch_rd[0] = 1'b0;
        tick(20);

        // Write on channel 1.
        b = tog[1];
        set_addr(1, 24'h77);
        ch_din[15:8] = 8'h3C;
        ch_wr[1] = 1'b1;
        #1;
        check("ch1_we", 32'(mem_we[1]), 1);
        check("ch1_addr", 32'(mem_addr[AW +: AW]), 32'h77);
        check("ch1_din", 32'(mem_din[15:8]), 32'h3C);
        tick(20);
        ch_wr[1] = 1'b0;
        check("ch1_toggles", 32'(tog[1] - b), 1);
        tick(20);

        // Reset dropped mid-sweep with a request outstanding.
        ack_dly = 4'd5;
        b = tog[2];
        reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (tog[2] - b >= 5 && mem_req[2] != mem_ack[2]) found = 1'b1;
        end
        check("mid_reached", 32'(found), 1);
        check("mid_tog", 32'(tog[2] - b), 5);
        check("mid_ovr_cleared", 32'(ch_ovr), 0);
        reset = 1'b0;
        set_addr(2, 24'h55);
        ch_rd[2] = 1'b1;
        b = tog[2];
        #1;
        check("mid_no_issue", 32'(mem_addr[2*AW +: AW]), 0);
        check("mid_busy", 32'(ch_busy[2]), 1);
        found = 1'b0;
        nb = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            nb++;
            if (tog[2] - b == 1) found = 1'b1;
        end
        check("mid_rd_issued", 32'(found), 1);
        check("mid_rd_waited", 32'(nb > 1), 1);
        check("mid_rd_addr", 32'(last_addr[2]), 32'h55);
        check("mid_rd_we", 32'(last_we[2]), 0);
        check("mid_clr_done", 32'(clr_done), 0);
        ch_rd[2] = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
